// File: rtl/collision_frame_loader.sv
// collision_frame_loader
//   Packs a 32-bit host word stream into 8-word frames and hands each frame to
//   the collision-detect control unit with an rdyData/wein handshake. A shadow
//   buffer fills in the background while the front frame is offered/held, so
//   the host can stream one frame ahead. After NUM_FRAMES handoffs load_done
//   rises and stays high until a restart pulse starts a new load.
//
// Ports
//   clk        in   1      clock, rising edge
//   rstmaster  in   1      asynchronous active-low reset
//   s_valid    in   1      host word valid
//   s_data     in   32     host word
//   s_ready    out  1      host word accepted on s_valid & s_ready (combinational)
//   restart    in   1      one-cycle pulse, start a new load
//   wein       in   1      control-unit write enable (handshake ack)
//   rdyData    out  1      frame on frm0..frm7 is offered
//   frm0..frm7 out  32     current frame, frm0 = first word received
//   frame_idx  out  IDX_W  frames fully handed off this load
//   load_done  out  1      all NUM_FRAMES handed off
module collision_frame_loader #(
  parameter int unsigned FRAME_WORDS = 8,
  parameter int unsigned NUM_FRAMES  = 32,
  parameter int unsigned IDX_W       = 6
) (
  input  logic             clk,
  input  logic             rstmaster,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  input  logic             restart,
  input  logic             wein,
  output logic             rdyData,
  output logic [31:0]      frm0,
  output logic [31:0]      frm1,
  output logic [31:0]      frm2,
  output logic [31:0]      frm3,
  output logic [31:0]      frm4,
  output logic [31:0]      frm5,
  output logic [31:0]      frm6,
  output logic [31:0]      frm7,
  output logic [IDX_W-1:0] frame_idx,
  output logic             load_done
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WCNT_W = $clog2(FRAME_WORDS);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_OFFER = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_shadow [FRAME_WORDS];
  logic [DATA_W-1:0] r_frm    [FRAME_WORDS];
  logic              r_shadow_full;
  logic [WCNT_W-1:0] r_wcnt;
  logic [IDX_W-1:0]  r_frames_in;
  logic [IDX_W-1:0]  r_frame_idx;
  logic              r_rdy;
  logic              r_load_done;

  logic w_accept;
  logic w_last_word;
  logic w_last_frame;
  logic w_restart_ok;
  logic w_xfer;
  logic w_rdy_nxt;
  logic w_idx_inc;
  logic w_set_done;

  // Host side handshake; stalls while the shadow is full or the load is complete.
  assign s_ready = !r_shadow_full && !r_load_done &&
                   (r_frames_in < IDX_W'(NUM_FRAMES));

  assign w_accept     = s_valid && s_ready;
  assign w_last_word  = (r_wcnt == WCNT_W'(FRAME_WORDS - 1));
  assign w_last_frame = (r_frame_idx == IDX_W'(NUM_FRAMES - 1));

  // Restart only takes effect when nothing is offered and no partial frame is buffered.
  assign w_restart_ok = restart &&
                        ((r_state == ST_EMPTY) || (r_state == ST_DONE)) &&
                        !r_shadow_full && (r_wcnt == '0);

  // State register
  always_ff @(posedge clk or negedge rstmaster) begin
    if (!rstmaster) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_restart_ok) begin
          w_state_nxt = ST_EMPTY;
        end else if (r_shadow_full) begin
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (wein) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!wein) begin
          if (w_last_frame) begin
            w_state_nxt = ST_DONE;
          end else if (r_shadow_full) begin
            w_state_nxt = ST_OFFER;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
      end
      ST_DONE: begin
        if (w_restart_ok) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Output/control decode: what the registers should do on the next edge
  always_comb begin
    w_xfer     = 1'b0;
    w_rdy_nxt  = 1'b0;
    w_idx_inc  = 1'b0;
    w_set_done = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_xfer    = r_shadow_full;
        w_rdy_nxt = r_shadow_full;
      end
      ST_OFFER: begin
        w_rdy_nxt = !wein;
      end
      ST_HOLD: begin
        if (!wein) begin
          w_idx_inc = 1'b1;
          if (w_last_frame) begin
            w_set_done = 1'b1;
          end else if (r_shadow_full) begin
            w_xfer    = 1'b1;
            w_rdy_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_rdy_nxt = 1'b0;
      end
    endcase
  end

  // Handoff status: rdyData, frame index and load_done
  always_ff @(posedge clk or negedge rstmaster) begin
    if (!rstmaster) begin
      r_rdy       <= 1'b0;
      r_frame_idx <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_rdy <= w_rdy_nxt;
      if (w_restart_ok) begin
        r_frame_idx <= '0;
        r_load_done <= 1'b0;
      end else begin
        if (w_idx_inc) begin
          r_frame_idx <= r_frame_idx + IDX_W'(1);
        end
        if (w_set_done) begin
          r_load_done <= 1'b1;
        end
      end
    end
  end

  // Shadow fill bookkeeping; a transfer and a last-word accept never coincide
  // because s_ready is low while the shadow is full.
  always_ff @(posedge clk or negedge rstmaster) begin
    if (!rstmaster) begin
      r_shadow_full <= 1'b0;
      r_wcnt        <= '0;
      r_frames_in   <= '0;
    end else begin
      if (w_accept) begin
        r_wcnt <= w_last_word ? '0 : r_wcnt + WCNT_W'(1);
      end
      if (w_accept && w_last_word) begin
        r_shadow_full <= 1'b1;
      end else if (w_xfer) begin
        r_shadow_full <= 1'b0;
      end
      if (w_restart_ok) begin
        r_frames_in <= '0;
      end else if (w_accept && w_last_word) begin
        r_frames_in <= r_frames_in + IDX_W'(1);
      end
    end
  end

  // Shadow word storage
  always_ff @(posedge clk or negedge rstmaster) begin
    if (!rstmaster) begin
      for (int i = 0; i < int'(FRAME_WORDS); i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_accept) begin
      r_shadow[r_wcnt] <= s_data;
    end
  end

  // Front frame, only reloaded on a shadow transfer so it is stable while wein is high
  always_ff @(posedge clk or negedge rstmaster) begin
    if (!rstmaster) begin
      for (int i = 0; i < int'(FRAME_WORDS); i++) begin
        r_frm[i] <= '0;
      end
    end else if (w_xfer) begin
      for (int i = 0; i < int'(FRAME_WORDS); i++) begin
        r_frm[i] <= r_shadow[i];
      end
    end
  end

  assign rdyData   = r_rdy;
  assign frame_idx = r_frame_idx;
  assign load_done = r_load_done;
  assign frm0      = r_frm[0];
  assign frm1      = r_frm[1];
  assign frm2      = r_frm[2];
  assign frm3      = r_frm[3];
  assign frm4      = r_frm[4];
  assign frm5      = r_frm[5];
  assign frm6      = r_frm[6];
  assign frm7      = r_frm[7];

endmodule

// File: tb/tb_collision_frame_loader.sv
// Testbench for collision_frame_loader with NUM_FRAMES=4: directed scenarios plus
// a randomized producer/consumer run checked against a word-queue reference.
module tb_collision_frame_loader;

  localparam int unsigned NF    = 4;
  localparam int unsigned IDX_W = 6;

  logic             clk = 1'b0;
  logic             rstmaster;
  logic             s_valid;
  logic [31:0]      s_data;
  logic             s_ready;
  logic             restart;
  logic             wein;
  logic             rdyData;
  logic [31:0]      frm0, frm1, frm2, frm3, frm4, frm5, frm6, frm7;
  logic [IDX_W-1:0] frame_idx;
  logic             load_done;

  logic [31:0] frm_o [8];
  assign frm_o[0] = frm0;
  assign frm_o[1] = frm1;
  assign frm_o[2] = frm2;
  assign frm_o[3] = frm3;
  assign frm_o[4] = frm4;
  assign frm_o[5] = frm5;
  assign frm_o[6] = frm6;
  assign frm_o[7] = frm7;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state for the randomized run
  logic [31:0] words_q [$];
  int          handed;
  int          accepted;
  int          max_outstanding;

  always #5 clk = ~clk;

  collision_frame_loader #(
    .FRAME_WORDS(8),
    .NUM_FRAMES (NF),
    .IDX_W      (IDX_W)
  ) dut (
    .clk      (clk),
    .rstmaster(rstmaster),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .restart  (restart),
    .wein     (wein),
    .rdyData  (rdyData),
    .frm0     (frm0),
    .frm1     (frm1),
    .frm2     (frm2),
    .frm3     (frm3),
    .frm4     (frm4),
    .frm5     (frm5),
    .frm6     (frm6),
    .frm7     (frm7),
    .frame_idx(frame_idx),
    .load_done(load_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstmaster = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    restart   = 1'b0;
    wein      = 1'b0;
    step();
    step();
    rstmaster = 1'b1;
    step();
  endtask

  // Offer one word and hold it until the DUT takes it (bounded)
  task automatic push_word(input logic [31:0] d);
    logic acc;
    int   t;
    s_valid = 1'b1;
    s_data  = d;
    t = 0;
    do begin
      acc = s_ready;
      step();
      t++;
    end while (!acc && t < 300);
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL push_timeout: word %h accepted=%b, required 1", d, acc);
    end
    s_valid = 1'b0;
  endtask

  task automatic handshake(input int hi_cycles);
    wein = 1'b1;
    repeat (hi_cycles) step();
    wein = 1'b0;
    step();
  endtask

  task automatic wait_rdy(input string name);
    int t;
    t = 0;
    while (rdyData !== 1'b1 && t < 500) begin
      step();
      t++;
    end
    n_checks++;
    if (rdyData !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_wait_rdy: rdyData=%b, required 1", name, rdyData);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (rdyData !== 1'b0 || load_done !== 1'b0 || frame_idx !== '0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b done=%b idx=%0d s_ready=%b, required 0 0 0 1",
               rdyData, load_done, frame_idx, s_ready);
    end
    for (int i = 0; i < 8; i++) push_word(32'hA0 + 32'(i));
    step();
    for (int i = 0; i < 3; i++) push_word(32'hB0 + 32'(i));
    #2;
    rstmaster = 1'b0;
    #1;
    n_checks++;
    if (rdyData !== 1'b0 || load_done !== 1'b0 || frame_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_async: rdy=%b done=%b idx=%0d, required 0 0 0",
               rdyData, load_done, frame_idx);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (frm_o[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_frm%0d: got %h, required 0", i, frm_o[i]);
      end
    end
    @(posedge clk);
    #1;
    rstmaster = 1'b1;
    step();
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: s_ready=%b, required 1", s_ready);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i));
    n_checks++;
    if (rdyData !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rdy_early: rdyData=%b at 8th accept edge, required 0", rdyData);
    end
    step();
    n_checks++;
    if (rdyData !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rdy_latency: rdyData=%b one edge after 8th accept, required 1", rdyData);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (frm_o[i] !== 32'h10 + 32'(i)) begin
        n_fail++;
        $display("FAIL single_frm%0d: got %h, required %h", i, frm_o[i], 32'h10 + 32'(i));
      end
    end
    wein = 1'b1;
    step();
    n_checks++;
    if (rdyData !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rdy_drop: rdyData=%b after first wein edge, required 0", rdyData);
    end
    step();
    step();
    n_checks++;
    if (rdyData !== 1'b0 || frame_idx !== IDX_W'(0) || frm_o[0] !== 32'h10 || frm_o[7] !== 32'h17) begin
      n_fail++;
      $display("FAIL single_hold: rdy=%b idx=%0d frm0=%h frm7=%h, required 0 0 10 17",
               rdyData, frame_idx, frm_o[0], frm_o[7]);
    end
    wein = 1'b0;
    step();
    n_checks++;
    if (frame_idx !== IDX_W'(1) || rdyData !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idx: idx=%0d rdy=%b after wein fall, required 1 0", frame_idx, rdyData);
    end
  endtask

  task automatic test_backpressure();
    int stall_bad;
    do_reset();
    for (int i = 1; i <= 16; i++) push_word(32'h100 + 32'(i));
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_after16: s_ready=%b, required 0", s_ready);
    end
    s_valid = 1'b1;
    s_data  = 32'h111;
    stall_bad = 0;
    repeat (5) begin
      if (s_ready !== 1'b0) stall_bad++;
      step();
    end
    n_checks++;
    if (stall_bad != 0) begin
      n_fail++;
      $display("FAIL bp_stall: s_ready high in %0d stalled cycles, required 0", stall_bad);
    end
    n_checks++;
    if (rdyData !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_rdy: rdyData=%b, required 1", rdyData);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (frm_o[i] !== 32'h101 + 32'(i)) begin
        n_fail++;
        $display("FAIL bp_first_frm%0d: got %h, required %h", i, frm_o[i], 32'h101 + 32'(i));
      end
    end
    handshake(1);
    n_checks++;
    if (rdyData !== 1'b1 || frame_idx !== IDX_W'(1) || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: rdy=%b idx=%0d s_ready=%b, required 1 1 1",
               rdyData, frame_idx, s_ready);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (frm_o[i] !== 32'h109 + 32'(i)) begin
        n_fail++;
        $display("FAIL bp_second_frm%0d: got %h, required %h", i, frm_o[i], 32'h109 + 32'(i));
      end
    end
    for (int i = 17; i <= 20; i++) push_word(32'h100 + 32'(i));
  endtask

  task automatic test_full_load();
    logic [31:0] f [8];
    do_reset();
    for (int k = 0; k < int'(NF); k++) begin
      for (int i = 0; i < 8; i++) begin
        f[i] = $urandom;
        push_word(f[i]);
      end
      wait_rdy("full");
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (frm_o[i] !== f[i]) begin
          n_fail++;
          $display("FAIL full_f%0d_frm%0d: got %h, required %h", k, i, frm_o[i], f[i]);
        end
      end
      handshake(int'($urandom_range(1, 3)));
    end
    n_checks++;
    if (load_done !== 1'b1 || frame_idx !== IDX_W'(NF) || s_ready !== 1'b0 || rdyData !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: done=%b idx=%0d s_ready=%b rdy=%b, required 1 %0d 0 0",
               load_done, frame_idx, s_ready, rdyData, NF);
    end
    wein = 1'b1;
    step();
    wein = 1'b0;
    step();
    n_checks++;
    if (load_done !== 1'b1 || frame_idx !== IDX_W'(NF) || rdyData !== 1'b0) begin
      n_fail++;
      $display("FAIL full_wein_in_done: done=%b idx=%0d rdy=%b, required 1 %0d 0",
               load_done, frame_idx, rdyData, NF);
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    n_checks++;
    if (load_done !== 1'b0 || frame_idx !== IDX_W'(0) || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_restart: done=%b idx=%0d s_ready=%b, required 0 0 1",
               load_done, frame_idx, s_ready);
    end
  endtask

  task automatic test_restart_ignored();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h300 + 32'(i));
    wait_rdy("rst_a");
    handshake(2);
    for (int i = 0; i < 8; i++) push_word(32'h400 + 32'(i));
    wait_rdy("rst_b");
    restart = 1'b1;
    step();
    restart = 1'b0;
    n_checks++;
    if (rdyData !== 1'b1 || frame_idx !== IDX_W'(1)) begin
      n_fail++;
      $display("FAIL restart_offer: rdy=%b idx=%0d, required 1 1", rdyData, frame_idx);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (frm_o[i] !== 32'h400 + 32'(i)) begin
        n_fail++;
        $display("FAIL restart_offer_frm%0d: got %h, required %h", i, frm_o[i], 32'h400 + 32'(i));
      end
    end
    wein = 1'b1;
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    n_checks++;
    if (rdyData !== 1'b0 || frame_idx !== IDX_W'(1)) begin
      n_fail++;
      $display("FAIL restart_hold: rdy=%b idx=%0d, required 0 1", rdyData, frame_idx);
    end
    wein = 1'b0;
    step();
    n_checks++;
    if (frame_idx !== IDX_W'(2)) begin
      n_fail++;
      $display("FAIL restart_hold_idx: idx=%0d, required 2", frame_idx);
    end
  endtask

  task automatic test_transfer_edge();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h600 + 32'(i));
    for (int i = 0; i < 8; i++) push_word(32'h700 + 32'(i));
    s_valid = 1'b1;
    s_data  = 32'h7777;
    handshake(1);
    n_checks++;
    if (rdyData !== 1'b1 || frm_o[0] !== 32'h700 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL xfer_b: rdy=%b frm0=%h s_ready=%b, required 1 700 1",
               rdyData, frm_o[0], s_ready);
    end
    push_word(32'h7777);
    for (int i = 1; i < 8; i++) push_word(32'h800 + 32'(i));
    handshake(1);
    n_checks++;
    if (rdyData !== 1'b1 || frame_idx !== IDX_W'(2) || frm_o[0] !== 32'h7777) begin
      n_fail++;
      $display("FAIL xfer_c: rdy=%b idx=%0d frm0=%h, required 1 2 7777",
               rdyData, frame_idx, frm_o[0]);
    end
    for (int i = 1; i < 8; i++) begin
      n_checks++;
      if (frm_o[i] !== 32'h800 + 32'(i)) begin
        n_fail++;
        $display("FAIL xfer_c_frm%0d: got %h, required %h", i, frm_o[i], 32'h800 + 32'(i));
      end
    end
  endtask

  // Random producer and consumer; frame k must equal words 8k..8k+7 in arrival order
  task automatic test_random();
    do_reset();
    words_q.delete();
    handed = 0;
    accepted = 0;
    max_outstanding = 0;
    fork
      begin : producer
        logic [31:0] d;
        for (int k = 0; k < int'(NF) * 8; k++) begin
          d = $urandom;
          repeat ($urandom_range(0, 2)) step();
          words_q.push_back(d);
          push_word(d);
          accepted++;
          if (accepted - 8 * handed > max_outstanding) max_outstanding = accepted - 8 * handed;
        end
      end
      begin : consumer
        for (int k = 0; k < int'(NF); k++) begin
          wait_rdy("rand");
          for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (words_q.size() <= 8 * k + i) begin
              n_fail++;
              $display("FAIL rand_f%0d_frm%0d: got %h, required a buffered word (none)", k, i, frm_o[i]);
            end else if (frm_o[i] !== words_q[8 * k + i]) begin
              n_fail++;
              $display("FAIL rand_f%0d_frm%0d: got %h, required %h", k, i, frm_o[i], words_q[8 * k + i]);
            end
          end
          repeat ($urandom_range(0, 2)) step();
          handshake(int'($urandom_range(1, 3)));
          handed++;
          n_checks++;
          if (frame_idx !== IDX_W'(k + 1)) begin
            n_fail++;
            $display("FAIL rand_idx%0d: idx=%0d, required %0d", k, frame_idx, k + 1);
          end
        end
      end
    join
    n_checks++;
    if (max_outstanding > 16) begin
      n_fail++;
      $display("FAIL rand_buffering: %0d words outstanding, required <= 16", max_outstanding);
    end
    n_checks++;
    if (load_done !== 1'b1 || frame_idx !== IDX_W'(NF) || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_done: done=%b idx=%0d s_ready=%b, required 1 %0d 0",
               load_done, frame_idx, s_ready, NF);
    end
  endtask

  initial begin
    rstmaster = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    restart   = 1'b0;
    wein      = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_full_load();
    test_restart_ignored();
    test_transfer_edge();
    for (int r = 0; r < 3; r++) test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
